// File: rtl/ps2_scan_rx_if.sv
// Event handshake between the PS/2 receiver and the key-handling logic.
// code_o/break_o/valid_o flow to the consumer; ready_i flows back.
interface ps2_scan_rx_if;
  logic [15:0] code_o;
  logic [1:0]  break_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    output code_o,
    output break_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  code_o,
    input  break_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: sync + deglitch, frame check, E0/F0 fold, event FIFO.
// Ports: clk_i, rst_i (async low), ps2_clk_i/ps2_data_i, clr_i, evt (master),
// level_o, frame_err_o, parity_err_o, overflow_o.
module ps2_scan_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ps2_clk_i,
  input  logic                        ps2_data_i,
  input  logic                        clr_i,
  ps2_scan_rx_if.master               evt,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overflow_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Synchronisers idle high so reset never creates a fake edge.
  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] dt_sync;
  logic                   ck_s;
  logic                   dt_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ck_sync <= '1;
      dt_sync <= '1;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dt_sync <= {dt_sync[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  assign ck_s = ck_sync[SYNC_STAGES-1];
  assign dt_s = dt_sync[SYNC_STAGES-1];

  // Level follows the synced clock only after FILTER_LEN
  // consecutive differing samples; data is latched with the fall.
  logic [FW-1:0] flt_cnt;
  logic          ck_flt;
  logic          fall;
  logic          fall_dat;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flt_cnt  <= '0;
      ck_flt   <= 1'b1;
      fall     <= 1'b0;
      fall_dat <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (ck_s == ck_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt  <= '0;
        ck_flt   <= ck_s;
        fall     <= ~ck_s;
        fall_dat <= dt_s;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } st_t;

  st_t           st;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          byte_vld;

  // shreg stays stable in IDLE, so the decoder reads it
  // in the cycle after byte_vld is raised.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st           <= S_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      to_cnt       <= '0;
      byte_vld     <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      byte_vld     <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      if (clr_i) begin
        st     <= S_IDLE;
        to_cnt <= '0;
      end else if (fall) begin
        to_cnt <= '0;
        unique case (st)
          S_IDLE: begin
            if (fall_dat) begin
              frame_err_o <= 1'b1;
            end else begin
              st      <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {fall_dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) st <= S_PAR;
          end
          S_PAR: begin
            par <= fall_dat;
            st  <= S_STOP;
          end
          S_STOP: begin
            st <= S_IDLE;
            if (!fall_dat) begin
              frame_err_o <= 1'b1;
            end else if (!(^{shreg, par})) begin
              parity_err_o <= 1'b1;
            end else begin
              byte_vld <= 1'b1;
            end
          end
          default: st <= S_IDLE;
        endcase
      end else if (st != S_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          frame_err_o <= 1'b1;
          st          <= S_IDLE;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Prefix folding; errors are raised only when byte_vld is low,
  // so kill and the byte terms never overlap.
  logic        ext;
  logic        brk;
  logic        kill;
  logic        hit_e0;
  logic        hit_f0;
  logic        emit;
  logic [17:0] emit_ent;

  always_comb begin
    kill     = clr_i | frame_err_o | parity_err_o;
    hit_e0   = 1'b0;
    hit_f0   = 1'b0;
    emit     = 1'b0;
    emit_ent = {(ext ? 8'hE0 : 8'h00), shreg, (brk ? 2'b01 : 2'b10)};
    if (byte_vld && !kill) begin
      hit_e0 = (shreg == 8'hE0);
      hit_f0 = (shreg == 8'hF0);
      emit   = !hit_e0 && !hit_f0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      unique case (1'b1)
        kill: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
        hit_e0: ext <= 1'b1;
        hit_f0: brk <= 1'b1;
        emit: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Show-ahead FIFO of {code, break} entries.
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign push  = emit;
  assign pop   = evt.valid_o & evt.ready_i & ~clr_i;
  // On full, a same-cycle pop frees the slot being written.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wp] <= emit_ent;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && full && !pop) overflow_o <= 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign evt.valid_o = (cnt != '0);
  assign evt.code_o  = evt.valid_o ? mem[rp][17:2] : 16'h0000;
  assign evt.break_o = evt.valid_o ? mem[rp][1:0] : 2'b00;
  assign level_o     = cnt;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: vector table plus corner sequences,
// expected events held in a scoreboard queue and popped on each handshake.
module tb_ps2_scan_rx;
  localparam int SYNC = 2;
  localparam int FLT  = 4;
  localparam int TMO  = 1000;
  localparam int DEP  = 8;
  localparam int H    = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c  = 1'b1;
  logic       ps2d  = 1'b1;
  logic       clr   = 1'b0;
  logic [3:0] level;
  logic       fe;
  logic       pe;
  logic       ovf;

  ps2_scan_rx_if bus();

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FLT),
    .TIMEOUT_CYC(TMO),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .ps2_clk_i   (ps2c),
    .ps2_data_i  (ps2d),
    .clr_i       (clr),
    .evt         (bus.master),
    .level_o     (level),
    .frame_err_o (fe),
    .parity_err_o(pe),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fe_n  = 0;
  int pe_n  = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_e;

  typedef struct {
    logic [7:0]  b [3];
    int          n;
    logic [15:0] code;
    logic [1:0]  brk;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if (fe) fe_n++;
    if (pe) pe_n++;
    if (rst_n && bus.valid_o && bus.ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h_%b", bus.code_o, bus.break_o);
      end else begin
        exp_e = sb.pop_front();
        if ({bus.code_o, bus.break_o} !== exp_e) begin
          bad++;
          $display("FAIL event got=%h_%b want=%h_%b",
                   bus.code_o, bus.break_o, exp_e[17:2], exp_e[1:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nfall,
                            input bit glitch, output int lat);
    logic [10:0] f;
    f   = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    lat = -1;
    for (int i = 0; i < nfall; i++) begin
      ps2d = f[i];
      tick(H / 2);
      if (glitch) begin
        ps2c = 1'b0;
        tick(1);
        ps2c = 1'b1;
      end
      tick(H / 2);
      ps2c = 1'b0;
      for (int k = 1; k <= H; k++) begin
        tick(1);
        if (glitch) ps2c = (k == H / 2);
        if (i == 10 && lat < 0 && bus.valid_o) lat = k;
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(H);
  endtask

  task automatic send(input logic [7:0] b);
    int d;
    send_frame(b, 1'b0, 1'b0, 11, 1'b0, d);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick(1);
    chk(nm, sb.size(), 0);
  endtask

  task automatic push_exp(input logic [15:0] c, input logic [1:0] k);
    sb.push_back({c, k});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=running want=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int fe0;
    int pe0;

    vecs[0] = '{b: '{8'hE0, 8'hF0, 8'h75}, n: 3, code: 16'hE075, brk: 2'b01};
    vecs[1] = '{b: '{8'hF0, 8'h1C, 8'h00}, n: 2, code: 16'h001C, brk: 2'b01};
    vecs[2] = '{b: '{8'hE0, 8'h75, 8'h00}, n: 2, code: 16'hE075, brk: 2'b10};
    vecs[3] = '{b: '{8'hE1, 8'h00, 8'h00}, n: 1, code: 16'h00E1, brk: 2'b10};
    vecs[4] = '{b: '{8'h5A, 8'h00, 8'h00}, n: 1, code: 16'h005A, brk: 2'b10};
    vecs[5] = '{b: '{8'hE0, 8'h00, 8'h00}, n: 2, code: 16'hE000, brk: 2'b10};

    bus.ready_i = 1'b1;
    tick(3);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_code", bus.code_o, 0);
    chk("rst_break", bus.break_o, 0);
    chk("rst_level", level, 0);
    chk("rst_ferr", fe, 0);
    chk("rst_perr", pe, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(5);

    // T1: single make with latency from the stop-bit clock edge
    push_exp(16'h001C, 2'b10);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, lat);
    chk("t1_latency", lat, SYNC + FLT + 2);
    drain("t1_drain");

    // table: prefix folding
    for (int v = 0; v < 6; v++) begin
      push_exp(vecs[v].code, vecs[v].brk);
      for (int j = 0; j < vecs[v].n; j++) send(vecs[v].b[j]);
      drain($sformatf("vec%0d_drain", v));
    end
    chk("table_ferr", fe_n, 0);
    chk("table_perr", pe_n, 0);

    // T3: parity error drops byte, next byte fine
    pe0 = pe_n;
    fe0 = fe_n;
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0, lat);
    chk("t3_perr", pe_n, pe0 + 1);
    chk("t3_no_ferr", fe_n, fe0);
    chk("t3_level", level, 0);
    push_exp(16'h0032, 2'b10);
    send(8'h32);
    drain("t3_drain");

    // parity error clears a pending E0 prefix
    push_exp(16'h0075, 2'b10);
    send(8'hE0);
    send_frame(8'h44, 1'b1, 1'b0, 11, 1'b0, lat);
    send(8'h75);
    drain("perr_prefix_drain");

    // bad stop bit
    fe0 = fe_n;
    pe0 = pe_n;
    send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, lat);
    chk("stop_ferr", fe_n, fe0 + 1);
    chk("stop_no_perr", pe_n, pe0);
    chk("stop_level", level, 0);

    // T4: timeout mid-frame, then prefix discarded by timeout
    fe0 = fe_n;
    send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0, lat);
    tick(TMO + 50);
    chk("t4_ferr", fe_n, fe0 + 1);
    send(8'hE0);
    send_frame(8'h11, 1'b0, 1'b0, 3, 1'b0, lat);
    tick(TMO + 50);
    chk("t4_ferr2", fe_n, fe0 + 2);
    push_exp(16'h0075, 2'b10);
    send(8'h75);
    drain("t4_drain");

    // reset mid-frame: no partial byte, fresh start next
    fe0 = fe_n;
    send_frame(8'h5A, 1'b0, 1'b0, 6, 1'b0, lat);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("mrst_level", level, 0);
    push_exp(16'h004B, 2'b10);
    send(8'h4B);
    drain("mrst_drain");
    chk("mrst_ferr", fe_n, fe0);

    // T6: glitches shorter than the filter
    fe0 = fe_n;
    pe0 = pe_n;
    push_exp(16'h005A, 2'b10);
    send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1, lat);
    drain("t6_drain");
    chk("t6_ferr", fe_n, fe0);
    chk("t6_perr", pe_n, pe0);

    // T5: overflow with ready low, ordered drain, clear
    bus.ready_i = 1'b0;
    for (int i = 0; i <= DEP; i++) begin
      if (i < DEP) push_exp({8'h00, 8'h10 + 8'(i)}, 2'b10);
      send(8'h10 + 8'(i));
    end
    tick(10);
    chk("t5_level_full", level, DEP);
    chk("t5_ovf", ovf, 1);
    chk("t5_head", bus.code_o, 16'h0010);
    bus.ready_i = 1'b1;
    drain("t5_drain");
    tick(2);
    chk("t5_level_empty", level, 0);
    chk("t5_ovf_sticky", ovf, 1);
    bus.ready_i = 1'b0;
    send(8'h21);
    send(8'h22);
    tick(5);
    chk("t5_level2", level, 2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_valid", bus.valid_o, 0);
    chk("clr_break", bus.break_o, 0);
    bus.ready_i = 1'b1;
    push_exp(16'h0029, 2'b10);
    send(8'h29);
    drain("post_clr_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
